// File: rtl/j4_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : j4_bus_arbiter_pkg
// Brief  : Shared region codes and arbiter state encoding for the j4 bus
//          arbiter and its RAM.
// Rev    : 1.0  initial release
// ============================================================================
package j4_bus_arbiter_pkg;

    // Address region codes taken from the top two address bits
    localparam logic [1:0] RGN_RAM  = 2'b01;
    localparam logic [1:0] RGN_MBOX = 2'b11;

    // Host-side arbitration states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage : j4_bus_arbiter_pkg
`default_nettype wire

// File: rtl/j4_ram.sv
`default_nettype none
// ============================================================================
// Module : j4_ram
// Brief  : 2**AWIDTH x WIDTH RAM, one synchronous write port and two
//          asynchronous read ports (core side and host side).
// Rev    : 1.0  initial release
// ============================================================================
module j4_ram #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [AWIDTH-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam int C_DEPTH = 2 ** AWIDTH;

    logic [WIDTH-1:0] r_mem [C_DEPTH];

    // Single write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule : j4_ram
`default_nettype wire

// File: rtl/j4_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : j4_bus_arbiter
// Brief  : Shares the j4 data-memory/mailbox bus between the core I/O port
//          (absolute priority, zero-wait reads) and a host valid/ready port
//          granted only in idle bus cycles, with a sticky starvation flag.
// Rev    : 1.0  initial release
// ============================================================================
module j4_bus_arbiter
    import j4_bus_arbiter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int AWIDTH   = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_we,
    input  logic             io_re,
    input  logic [WIDTH-1:0] io_ptr,
    input  logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_in,
    input  logic             host_valid,
    input  logic             host_we,
    input  logic [WIDTH-1:0] host_addr,
    input  logic [WIDTH-1:0] host_wdata,
    output logic             host_ready,
    output logic             host_rvalid,
    output logic [WIDTH-1:0] host_rdata,
    output logic             host_starved,
    input  logic             starve_clr
);

    localparam int              CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   C_MAX_WAIT = CW'(MAX_WAIT);
    localparam logic [CW-1:0]   C_CNT_ONE  = CW'(1);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [CW-1:0]      r_wait_cnt;
    logic [CW-1:0]      w_wait_cnt_next;
    logic               r_starved;
    logic               w_starve_set;
    logic [WIDTH-1:0]   r_mbox;
    logic [WIDTH-1:0]   r_host_rdata;

    logic               w_core_busy;
    logic               w_host_ready;
    logic [1:0]         w_core_rgn;
    logic [1:0]         w_host_rgn;
    logic [WIDTH-1:0]   w_ram_rd_core;
    logic [WIDTH-1:0]   w_ram_rd_host;
    logic [WIDTH-1:0]   w_core_rd;
    logic [WIDTH-1:0]   w_host_rd;

    logic               w_wr_en;
    logic [WIDTH-1:0]   w_wr_addr;
    logic [WIDTH-1:0]   w_wr_data;
    logic [1:0]         w_wr_rgn;
    logic               w_ram_we;
    logic               w_mbox_we;
    logic               w_unused_bits;

    // Maps a region code to the word seen on a read; unmapped regions read 0
    function automatic logic [WIDTH-1:0] f_decode(
        input logic [1:0]       rgn,
        input logic [WIDTH-1:0] ram_word,
        input logic [WIDTH-1:0] mbox_word
    );
        logic [WIDTH-1:0] v;
        v = '0;
        if (rgn == RGN_RAM) begin
            v = ram_word;
        end else if (rgn == RGN_MBOX) begin
            v = mbox_word;
        end
        return v;
    endfunction

    assign w_core_rgn = io_ptr[WIDTH-1 -: 2];
    assign w_host_rgn = host_addr[WIDTH-1 -: 2];

    // Address bits between the RAM index and the region field are don't-care
    assign w_unused_bits = ^{io_ptr[WIDTH-3:AWIDTH], host_addr[WIDTH-3:AWIDTH]};

    assign w_core_busy = io_we | io_re;

    // Host only gets cycles the core leaves idle, never while acking, never in reset
    assign w_host_ready = host_valid & ~w_core_busy & (r_state != ST_RESP) & ~rst;

    // Core and host can never both write in one cycle, so one write port is enough
    assign w_wr_en   = io_we | (w_host_ready & host_we);
    assign w_wr_addr = io_we ? io_ptr : host_addr;
    assign w_wr_data = io_we ? io_out : host_wdata;
    assign w_wr_rgn  = w_wr_addr[WIDTH-1 -: 2];
    assign w_ram_we  = w_wr_en & (w_wr_rgn == RGN_RAM);
    assign w_mbox_we = w_wr_en & (w_wr_rgn == RGN_MBOX);

    j4_ram #(
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (w_ram_we),
        .waddr   (w_wr_addr[AWIDTH-1:0]),
        .wdata   (w_wr_data),
        .raddr_a (io_ptr[AWIDTH-1:0]),
        .rdata_a (w_ram_rd_core),
        .raddr_b (host_addr[AWIDTH-1:0]),
        .rdata_b (w_ram_rd_host)
    );

    assign w_core_rd = f_decode(w_core_rgn, w_ram_rd_core, r_mbox);
    assign w_host_rd = f_decode(w_host_rgn, w_ram_rd_host, r_mbox);
    assign io_in     = io_re ? w_core_rd : '0;

    // Mailbox register shared by both masters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mbox <= '0;
        end else if (w_mbox_we) begin
            r_mbox <= w_wr_data;
        end
    end

    // Host arbitration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Host arbitration next state: grant, wait behind the core, or ack
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_host_ready) begin
                    w_state_next = ST_RESP;
                end else if (host_valid & w_core_busy) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_host_ready) begin
                    w_state_next = ST_RESP;
                end else if (!host_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Host read data is captured at the accept edge; writes return 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_host_rdata <= '0;
        end else if (w_host_ready) begin
            r_host_rdata <= host_we ? '0 : w_host_rd;
        end
    end

    // Wait counter: counts blocked WAIT cycles, saturating, cleared otherwise
    always_comb begin
        w_wait_cnt_next = '0;
        if ((r_state == ST_WAIT) && host_valid && !w_host_ready) begin
            if (r_wait_cnt == C_MAX_WAIT) begin
                w_wait_cnt_next = C_MAX_WAIT;
            end else begin
                w_wait_cnt_next = r_wait_cnt + C_CNT_ONE;
            end
        end
    end

    assign w_starve_set = (r_state == ST_WAIT) & host_valid & ~w_host_ready
                        & (w_wait_cnt_next == C_MAX_WAIT);

    // Wait counter and sticky starvation flag; a new set beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_starved  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
            r_starved  <= w_starve_set | (r_starved & ~starve_clr);
        end
    end

    assign host_ready   = w_host_ready;
    assign host_rvalid  = (r_state == ST_RESP);
    assign host_rdata   = r_host_rdata;
    assign host_starved = r_starved;

endmodule : j4_bus_arbiter
`default_nettype wire
